// File: rtl/vc_fifo_pkg.sv
// -----------------------------------------------------------------------------
// vc_fifo_pkg
// Shared helpers for the multi-channel (virtual-channel) FIFO:
//   vc_clog2     - ceiling log2 used to size pointers and channel selects
//   calc_aw      - pointer index width for a given per-channel depth
//   calc_cw      - channel select width, never narrower than one bit
//   count_lsb    - bit offset of one channel's field in the packed count bus
//   ch_in_range  - true when a channel select names an existing channel
// -----------------------------------------------------------------------------
package vc_fifo_pkg;

  // Smallest r such that 2**r >= value (0 for value <= 1).
  function automatic int vc_clog2(input int value);
    int r;
    r = 32'sd0;
    while ((32'sd1 << r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

  function automatic int calc_aw(input int depth);
    return vc_clog2(depth);
  endfunction

  // A single channel still needs a one-bit select port.
  function automatic int calc_cw(input int num_ch);
    int r;
    r = vc_clog2(num_ch);
    return (r < 32'sd1) ? 32'sd1 : r;
  endfunction

  function automatic int count_lsb(input int ch, input int aw);
    return ch * (aw + 32'sd1);
  endfunction

  // Compared at 32 bits so a select that can never overflow still compiles
  // to a clean constant instead of an out-of-range comparison.
  function automatic logic ch_in_range(input logic [31:0] ch, input int num_ch);
    return (ch < 32'(num_ch));
  endfunction

endpackage

// File: rtl/vc_fifo_ptr.sv
// -----------------------------------------------------------------------------
// vc_fifo_ptr
// Read/write pointer pair for one channel of vc_fifo. Pointers are AW+1 bits:
// the low AW bits index the channel's slice of the shared memory and the MSB
// is a wrap bit that separates full from empty.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   inc_wr, inc_rd  advance the write / read pointer at the next edge
//   wr_ptr, rd_ptr  current pointers
//   full, empty     derived from the registered pointers only
//   count           occupancy, wr_ptr - rd_ptr modulo 2**(AW+1)
// -----------------------------------------------------------------------------
module vc_fifo_ptr
  import vc_fifo_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_wr,
  input  logic        inc_rd,
  output logic [AW:0] wr_ptr,
  output logic [AW:0] rd_ptr,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] PTR_ZERO = {(AW + 1){1'b0}};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  // Next-pointer computation; pointers wrap naturally through the MSB.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (inc_wr) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (inc_rd) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count  = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/vc_fifo.sv
// -----------------------------------------------------------------------------
// vc_fifo
// NUM_CH independent FIFOs of DEPTH words each, sharing one statically
// partitioned memory addressed as {channel, entry}. One write and one read per
// cycle on any channels. Read data is registered (latency 1, push_out marks it).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   wr, wr_ch     write request and target channel; datain is the word
//   rd, rd_ch     read request and source channel
//   dout          registered read data (holds when nothing is read)
//   push_out      one-cycle pulse, dout carries a freshly read word
//   full, empty   per-channel status from registered pointers
//   almost_full   per-channel count >= AF_THRESH
//   count         per-channel occupancy, channel c at [c*(AW+1) +: AW+1]
// Optional build macro VC_FIFO_ERR_EN adds:
//   err_clr       synchronous clear of the sticky error flags
//   ovf_err       sticky, write aimed at a full channel
//   udf_err       sticky, read aimed at an empty channel
// -----------------------------------------------------------------------------
module vc_fifo
  import vc_fifo_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 8,
  parameter int NUM_CH    = 4,
  parameter int AF_THRESH = 6,
  localparam int AW       = calc_aw(DEPTH),
  localparam int CW       = calc_cw(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [CW-1:0]            wr_ch,
  input  logic [WIDTH-1:0]         datain,
  input  logic                     rd,
  input  logic [CW-1:0]            rd_ch,
  output logic [WIDTH-1:0]         dout,
  output logic                     push_out,
  output logic [NUM_CH-1:0]        full,
  output logic [NUM_CH-1:0]        empty,
  output logic [NUM_CH-1:0]        almost_full,
`ifdef VC_FIFO_ERR_EN
  input  logic                     err_clr,
  output logic [NUM_CH-1:0]        ovf_err,
  output logic [NUM_CH-1:0]        udf_err,
`endif
  output logic [NUM_CH*(AW+1)-1:0] count
);

  localparam int          MEM_WORDS = NUM_CH * DEPTH;
  localparam logic [AW:0] AF_LVL    = AF_THRESH[AW:0];

  logic [WIDTH-1:0] mem_q [MEM_WORDS];

  logic [AW:0]       wr_ptr   [NUM_CH];
  logic [AW:0]       rd_ptr   [NUM_CH];
  logic [AW:0]       ch_count [NUM_CH];
  logic [NUM_CH-1:0] inc_wr;
  logic [NUM_CH-1:0] inc_rd;

  logic              wr_in_range;
  logic              rd_in_range;
  logic              wr_ok;
  logic              rd_ok;
  logic [CW+AW-1:0]  wr_addr;
  logic [CW+AW-1:0]  rd_addr;

  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              push_out_q, push_out_d;

  // Per-channel pointer pairs.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    vc_fifo_ptr #(.AW(AW)) u_ptr (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc_wr (inc_wr[c]),
      .inc_rd (inc_rd[c]),
      .wr_ptr (wr_ptr[c]),
      .rd_ptr (rd_ptr[c]),
      .full   (full[c]),
      .empty  (empty[c]),
      .count  (ch_count[c])
    );
    assign count[count_lsb(c, AW) +: AW + 1] = ch_count[c];
    assign almost_full[c] = (ch_count[c] >= AF_LVL);
  end

  // Accept decisions from pre-edge status; a full channel refuses the write
  // even when the same-cycle read frees a slot, and an empty one refuses the
  // read even when the same-cycle write fills it.
  always_comb begin
    wr_in_range = ch_in_range(32'(wr_ch), NUM_CH);
    rd_in_range = ch_in_range(32'(rd_ch), NUM_CH);
    wr_ok       = 1'b0;
    rd_ok       = 1'b0;
    inc_wr      = {NUM_CH{1'b0}};
    inc_rd      = {NUM_CH{1'b0}};
    wr_addr     = {wr_ch, wr_ptr[wr_ch][AW-1:0]};
    rd_addr     = {rd_ch, rd_ptr[rd_ch][AW-1:0]};
    if (wr && wr_in_range) begin
      wr_ok = !full[wr_ch];
    end else begin
      wr_ok = 1'b0;
    end
    if (rd && rd_in_range) begin
      rd_ok = !empty[rd_ch];
    end else begin
      rd_ok = 1'b0;
    end
    if (wr_ok) begin
      inc_wr[wr_ch] = 1'b1;
    end else begin
      inc_wr = {NUM_CH{1'b0}};
    end
    if (rd_ok) begin
      inc_rd[rd_ch] = 1'b1;
    end else begin
      inc_rd = {NUM_CH{1'b0}};
    end
  end

  // Shared storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_addr] <= datain;
    end
  end

  // Next read-data register value; dout holds when nothing is read.
  always_comb begin
    dout_d     = dout_q;
    push_out_d = 1'b0;
    if (rd_ok) begin
      dout_d     = mem_q[rd_addr];
      push_out_d = 1'b1;
    end else begin
      dout_d     = dout_q;
      push_out_d = 1'b0;
    end
  end

  // Read-data output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= {WIDTH{1'b0}};
      push_out_q <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      push_out_q <= push_out_d;
    end
  end

  assign dout     = dout_q;
  assign push_out = push_out_q;

`ifdef VC_FIFO_ERR_EN
  logic [NUM_CH-1:0] ovf_err_q, ovf_err_d;
  logic [NUM_CH-1:0] udf_err_q, udf_err_d;
  logic [NUM_CH-1:0] ovf_set;
  logic [NUM_CH-1:0] udf_set;

  // Sticky error flags; a new event in the clearing cycle survives the clear.
  always_comb begin
    ovf_set = {NUM_CH{1'b0}};
    udf_set = {NUM_CH{1'b0}};
    if (wr && wr_in_range && full[wr_ch]) begin
      ovf_set[wr_ch] = 1'b1;
    end else begin
      ovf_set = {NUM_CH{1'b0}};
    end
    if (rd && rd_in_range && empty[rd_ch]) begin
      udf_set[rd_ch] = 1'b1;
    end else begin
      udf_set = {NUM_CH{1'b0}};
    end
    if (err_clr) begin
      ovf_err_d = ovf_set;
      udf_err_d = udf_set;
    end else begin
      ovf_err_d = ovf_err_q | ovf_set;
      udf_err_d = udf_err_q | udf_set;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err_q <= {NUM_CH{1'b0}};
      udf_err_q <= {NUM_CH{1'b0}};
    end else begin
      ovf_err_q <= ovf_err_d;
      udf_err_q <= udf_err_d;
    end
  end

  assign ovf_err = ovf_err_q;
  assign udf_err = udf_err_q;
`endif

endmodule

// File: tb/tb_vc_fifo.sv
// -----------------------------------------------------------------------------
// tb_vc_fifo
// Directed bench for vc_fifo (default parameters). A queue-per-channel model
// tracks what every output must be; a negedge process compares the DUT with it
// every cycle, and the directed sequences add literal expectations.
// Build with VC_FIFO_ERR_EN to also exercise the sticky error flags.
// -----------------------------------------------------------------------------
module tb_vc_fifo;

  localparam int WIDTH     = 64;
  localparam int DEPTH     = 8;
  localparam int NUM_CH    = 4;
  localparam int AF_THRESH = 6;
  localparam int AW        = 3;
  localparam int CW        = 2;

  logic                     clk    = 1'b0;
  logic                     rst_n  = 1'b0;
  logic                     wr     = 1'b0;
  logic [CW-1:0]            wr_ch  = '0;
  logic [WIDTH-1:0]         datain = '0;
  logic                     rd     = 1'b0;
  logic [CW-1:0]            rd_ch  = '0;
  logic [WIDTH-1:0]         dout;
  logic                     push_out;
  logic [NUM_CH-1:0]        full;
  logic [NUM_CH-1:0]        empty;
  logic [NUM_CH-1:0]        almost_full;
  logic [NUM_CH*(AW+1)-1:0] count;
`ifdef VC_FIFO_ERR_EN
  logic                     err_clr = 1'b0;
  logic [NUM_CH-1:0]        ovf_err;
  logic [NUM_CH-1:0]        udf_err;
`endif

  vc_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .AF_THRESH(AF_THRESH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr(wr), .wr_ch(wr_ch), .datain(datain),
    .rd(rd), .rd_ch(rd_ch),
    .dout(dout), .push_out(push_out),
    .full(full), .empty(empty), .almost_full(almost_full),
`ifdef VC_FIFO_ERR_EN
    .err_clr(err_clr), .ovf_err(ovf_err), .udf_err(udf_err),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW:0] cnt(input int c);
    return count[c*(AW+1) +: AW+1];
  endfunction

  // ---------------- behavioural model ----------------
  logic [63:0]       mq [NUM_CH][$];
  logic [63:0]       m_dout = '0;
  logic              m_push = 1'b0;
  logic [NUM_CH-1:0] m_ovf  = '0;
  logic [NUM_CH-1:0] m_udf  = '0;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    m_dout = '0;
    m_push = 1'b0;
    m_ovf  = '0;
    m_udf  = '0;
  endtask

  // Applies one clock edge of the FIFO rules to the queues, using the
  // occupancy seen before the edge for every decision.
  task automatic model_edge(input logic w, input int wc, input logic [63:0] d,
                            input logic r, input int rc, input logic clr);
    int  wn, rn;
    bit  w_valid, r_valid;
    w_valid = (wc < NUM_CH);
    r_valid = (rc < NUM_CH);
    wn = w_valid ? mq[wc].size() : 0;
    rn = r_valid ? mq[rc].size() : 0;
    if (clr) begin
      m_ovf = '0;
      m_udf = '0;
    end
    if (w && w_valid && wn == DEPTH) m_ovf[wc] = 1'b1;
    if (r && r_valid && rn == 0)     m_udf[rc] = 1'b1;
    if (r && r_valid && rn > 0) begin
      m_dout = mq[rc].pop_front();
      m_push = 1'b1;
    end else begin
      m_push = 1'b0;
    end
    if (w && w_valid && wn < DEPTH) mq[wc].push_back(d);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("dout", dout, m_dout);
    chk("push_out", 64'(push_out), 64'(m_push));
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("full[%0d]", c),  64'(full[c]),  64'(mq[c].size() == DEPTH));
      chk($sformatf("empty[%0d]", c), 64'(empty[c]), 64'(mq[c].size() == 0));
      chk($sformatf("almost_full[%0d]", c), 64'(almost_full[c]), 64'(mq[c].size() >= AF_THRESH));
      chk($sformatf("count[%0d]", c), 64'(cnt(c)), 64'(mq[c].size()));
    end
`ifdef VC_FIFO_ERR_EN
    chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
    chk("udf_err", 64'(udf_err), 64'(m_udf));
`endif
  end

  // One clock cycle of stimulus; returns 1 time unit after the edge.
  task automatic step(input logic w, input int wc, input logic [63:0] d,
                      input logic r, input int rc, input logic clr = 1'b0);
    wr     = w;
    wr_ch  = wc[CW-1:0];
    datain = d;
    rd     = r;
    rd_ch  = rc[CW-1:0];
`ifdef VC_FIFO_ERR_EN
    err_clr = clr;
`endif
    @(posedge clk);
    model_edge(w, wc, d, r, rc, clr);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 0, 64'h0, 1'b0, 0);
  endtask

  initial begin
    #12;
    rst_n = 1'b1;
    chk("reset_empty", 64'(empty), 64'hF);
    chk("reset_count", 64'(count), 64'h0);

    // 1: reset while channels hold data
    step(1'b1, 0, 64'h11, 1'b0, 0);
    step(1'b1, 1, 64'h22, 1'b0, 0);
    step(1'b1, 0, 64'h33, 1'b0, 0);
    step(1'b0, 0, 64'h0, 1'b1, 0);
    chk("t1_pre_dout", dout, 64'h11);
    chk("t1_pre_push", 64'(push_out), 64'h1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t1_rst_empty", 64'(empty), 64'hF);
    chk("t1_rst_full", 64'(full), 64'h0);
    chk("t1_rst_af", 64'(almost_full), 64'h0);
    chk("t1_rst_count", 64'(count), 64'h0);
    chk("t1_rst_dout", dout, 64'h0);
    chk("t1_rst_push", 64'(push_out), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 0, 64'h0, 1'b1, 0);
    chk("t1_post_push", 64'(push_out), 64'h0);

    // 2: fill ch0, overflow attempt, drain in order
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 0, 64'(i), 1'b0, 0);
      chk($sformatf("t2_af_cnt%0d", i), 64'(almost_full[0]), (i >= 6) ? 64'h1 : 64'h0);
    end
    chk("t2_full", 64'(full[0]), 64'h1);
    step(1'b1, 0, 64'h9, 1'b0, 0);
    chk("t2_cnt_after_drop", 64'(cnt(0)), 64'h8);
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 0, 64'h0, 1'b1, 0);
      chk($sformatf("t2_rd%0d", i), dout, 64'(i));
      chk($sformatf("t2_push%0d", i), 64'(push_out), 64'h1);
    end
    idle();
    chk("t2_push_idle", 64'(push_out), 64'h0);
    chk("t2_dout_hold", dout, 64'h8);
    chk("t2_empty", 64'(empty[0]), 64'h1);

    // 3: wrap on ch1 with a standing occupancy of three
    for (int i = 0; i < 3; i++) step(1'b1, 1, 64'h100 + 64'(i), 1'b0, 0);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1, 64'h103 + 64'(k), 1'b1, 1);
      chk($sformatf("t3_rd%0d", k), dout, 64'h100 + 64'(k));
      chk($sformatf("t3_cnt%0d", k), 64'(cnt(1)), 64'h3);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 0, 64'h0, 1'b1, 1);
      chk($sformatf("t3_drain%0d", k), dout, 64'h114 + 64'(k));
    end

    // 4: same-channel write+read on full and on empty ch2
    for (int i = 0; i < DEPTH; i++) step(1'b1, 2, 64'h200 + 64'(i), 1'b0, 0);
    step(1'b1, 2, 64'hDEAD, 1'b1, 2);
    chk("t4_full_rd", dout, 64'h200);
    chk("t4_full_push", 64'(push_out), 64'h1);
    chk("t4_full_cnt", 64'(cnt(2)), 64'h7);
    for (int i = 1; i < DEPTH; i++) begin
      step(1'b0, 0, 64'h0, 1'b1, 2);
      chk($sformatf("t4_drain%0d", i), dout, 64'h200 + 64'(i));
    end
    chk("t4_empty", 64'(empty[2]), 64'h1);
    step(1'b1, 2, 64'h2A, 1'b1, 2);
    chk("t4_empty_push", 64'(push_out), 64'h0);
    chk("t4_empty_cnt", 64'(cnt(2)), 64'h1);
    step(1'b0, 0, 64'h0, 1'b1, 2);
    chk("t4_bypassless_rd", dout, 64'h2A);

    // 5: channel isolation (with four channels every select is in range)
    step(1'b1, 0, 64'h50, 1'b0, 0);
    step(1'b1, 0, 64'h51, 1'b0, 0);
    step(1'b1, 3, 64'hAA, 1'b1, 0);
    chk("t5_rd_ch0", dout, 64'h50);
    chk("t5_cnt3", 64'(cnt(3)), 64'h1);
    chk("t5_cnt0", 64'(cnt(0)), 64'h1);
    step(1'b0, 0, 64'h0, 1'b1, 0);
    chk("t5_rd_ch0b", dout, 64'h51);
    step(1'b0, 0, 64'h0, 1'b1, 3);
    chk("t5_rd_ch3", dout, 64'hAA);
    chk("t5_all_empty", 64'(empty), 64'hF);

`ifdef VC_FIFO_ERR_EN
    // 6: sticky error flags
    for (int i = 0; i < DEPTH; i++) step(1'b1, 0, 64'h300 + 64'(i), 1'b0, 0);
    chk("t6_no_ovf_yet", 64'(ovf_err), 64'h0);
    step(1'b1, 0, 64'h399, 1'b0, 0);
    chk("t6_ovf_set", 64'(ovf_err), 64'h1);
    idle();
    chk("t6_ovf_sticky", 64'(ovf_err), 64'h1);
    step(1'b1, 0, 64'h39A, 1'b0, 0, 1'b1);
    chk("t6_set_wins", 64'(ovf_err), 64'h1);
    step(1'b0, 0, 64'h0, 1'b0, 0, 1'b1);
    chk("t6_ovf_clr", 64'(ovf_err), 64'h0);
    step(1'b0, 0, 64'h0, 1'b1, 1);
    chk("t6_udf_set", 64'(udf_err), 64'h2);
    chk("t6_udf_push", 64'(push_out), 64'h0);
`endif

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
